// File: rtl/line_fill_memory.sv
// Burst backing memory for the data cache: line fills and writebacks of LINE_WORDS beats after LATENCY wait cycles.
// Optional LINE_FILL_MEMORY_BOUNDS_EN: out-of-range requests read 0, drop writes and flag mem_err with mem_done.
module line_fill_memory #(
  parameter int DEPTH_LOG2 = 16,
  parameter int LATENCY    = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_req,
  input  logic [31:0]                   mem_addr,
  input  logic                          mem_wr_en,
  input  logic [31:0]                   mem_wr_data,
  output logic [31:0]                   mem_read,
  output logic                          mem_valid,
  output logic [$clog2(LINE_WORDS)-1:0] mem_beat,
  output logic                          mem_busy,
`ifdef LINE_FILL_MEMORY_BOUNDS_EN
  output logic                          mem_err,
`endif
  output logic                          mem_done
);
  localparam int BW     = $clog2(LINE_WORDS);
  localparam int LAT_N  = (LATENCY > 0) ? LATENCY : 1;
  localparam int CW     = $clog2(LAT_N + 1);
  localparam logic [CW-1:0] LAT_LAST  = CW'(LAT_N - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [CW-1:0]         lat_cnt;
  logic [DEPTH_LOG2-1:0] base;
  logic                  rw;
  logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0] line_addr, rd_idx, wr_idx;
  logic                  rd_fire;
  logic                  blocked;

  assign line_addr = {mem_addr[DEPTH_LOG2-1:BW], {BW{1'b0}}};
  assign wr_idx    = base | DEPTH_LOG2'(mem_beat);

  assign mem_valid = (state == S_BURST);
  assign mem_busy  = (state != S_IDLE);
  assign mem_done  = (state == S_DONE);

`ifdef LINE_FILL_MEMORY_BOUNDS_EN
  logic oob;
  // In IDLE the request being accepted is judged directly, so a zero-latency fill is blocked too.
  assign blocked = (state == S_IDLE) ? (|mem_addr[31:DEPTH_LOG2]) : oob;
  assign mem_err = (state == S_DONE) && oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          oob <= 1'b0;
    else if (state == S_IDLE && mem_req) oob <= |mem_addr[31:DEPTH_LOG2];
  end
`else
  assign blocked = 1'b0;
  logic unused_hi;
  assign unused_hi = ^mem_addr[31:DEPTH_LOG2];
`endif

  logic unused_lo;
  assign unused_lo = ^mem_addr[BW-1:0];

  // Read is issued one edge ahead of each beat so mem_read is registered yet aligned with mem_valid.
  always_comb begin
    rd_fire = 1'b0;
    rd_idx  = base;
    case (state)
      S_IDLE: if (mem_req && LATENCY == 0) begin
        rd_fire = 1'b1;
        rd_idx  = line_addr;
      end
      S_WAIT: if (lat_cnt == LAT_LAST) rd_fire = 1'b1;
      S_BURST: if (mem_beat != BEAT_LAST) begin
        rd_fire = 1'b1;
        rd_idx  = base | DEPTH_LOG2'(mem_beat + 1'b1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      base     <= '0;
      rw       <= 1'b0;
      mem_beat <= '0;
      mem_read <= '0;
    end else begin
      case (state)
        S_IDLE: if (mem_req) begin
          base     <= line_addr;
          rw       <= mem_wr_en;
          lat_cnt  <= '0;
          mem_beat <= '0;
          state    <= (LATENCY == 0) ? S_BURST : S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) state   <= S_BURST;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
        S_BURST: begin
          if (mem_beat == BEAT_LAST) begin
            state    <= S_DONE;
            mem_beat <= '0;
          end else begin
            mem_beat <= mem_beat + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (rd_fire) mem_read <= blocked ? 32'h0 : mem[rd_idx];
    end
  end

  // Array has no reset; reset drops state to IDLE so pending beats never commit.
  always_ff @(posedge clk) begin
    if (state == S_BURST && rw && !blocked) mem[wr_idx] <= mem_wr_data;
  end
endmodule

// File: tb/tb_line_fill_memory.sv
// Bench for line_fill_memory: three instances (default, zero latency, 16-word wrapping) against a word-map model.
module tb_line_fill_memory;
  localparam int LW = 4;
  localparam int LATS [3] = '{2, 0, 1};
  localparam int DEPS [3] = '{16, 16, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wr_data;
  logic        mem_wr_en;
  logic        req  [3];
  logic [31:0] rd   [3];
  logic        vld  [3];
  logic [1:0]  beat [3];
  logic        busy [3];
  logic        done [3];
  logic        err  [3];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] wd [LW];
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

`ifdef LINE_FILL_MEMORY_BOUNDS_EN
  `define ERR_PORT(i) .mem_err(err[i]),
`else
  `define ERR_PORT(i)
  initial for (int i = 0; i < 3; i++) err[i] = 1'b0;
`endif

  line_fill_memory #(.DEPTH_LOG2(16), .LATENCY(2), .LINE_WORDS(LW)) u0 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[0]), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_read(rd[0]), .mem_valid(vld[0]), .mem_beat(beat[0]),
    .mem_busy(busy[0]), `ERR_PORT(0) .mem_done(done[0]));
  line_fill_memory #(.DEPTH_LOG2(16), .LATENCY(0), .LINE_WORDS(LW)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[1]), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_read(rd[1]), .mem_valid(vld[1]), .mem_beat(beat[1]),
    .mem_busy(busy[1]), `ERR_PORT(1) .mem_done(done[1]));
  line_fill_memory #(.DEPTH_LOG2(4), .LATENCY(1), .LINE_WORDS(LW)) u2 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[2]), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_read(rd[2]), .mem_valid(vld[2]), .mem_beat(beat[2]),
    .mem_busy(busy[2]), `ERR_PORT(2) .mem_done(done[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_read%0d", s), rd[s], 0);
      chk($sformatf("rst_valid%0d", s), 32'(vld[s]), 0);
      chk($sformatf("rst_beat%0d", s), 32'(beat[s]), 0);
      chk($sformatf("rst_busy%0d", s), 32'(busy[s]), 0);
      chk($sformatf("rst_done%0d", s), 32'(done[s]), 0);
      chk($sformatf("rst_err%0d", s), 32'(err[s]), 0);
    end
  endtask

  task automatic set_wd_rand();
    for (int i = 0; i < LW; i++) wd[i] = $urandom;
  endtask

  // One burst on instance sel. hold keeps mem_req high into the next burst; pre means the
  // caller is at the DONE cycle of a held burst. abort_b>=0 resets during that write beat.
  task automatic burst(input int sel, input logic [31:0] addr, input logic wr,
                       input bit hold, input bit pre, input int abort_b);
    int lat, d, b, key;
    longint base;
    bit oob, last_ok;
    logic [31:0] last, exp;
    lat = LATS[sel];
    d = DEPS[sel];
    base = longint'(addr) & ~longint'(LW - 1);
    oob = 1'b0;
    last_ok = 1'b0;
    last = '0;
`ifdef LINE_FILL_MEMORY_BOUNDS_EN
    oob = (addr >> d) != 0;
`endif
    mem_addr = addr;
    mem_wr_en = wr;
    req[sel] = 1'b1;
    if (pre) begin
      @(posedge clk);
      @(negedge clk);
      chk("gap_idle_busy", 32'(busy[sel]), 0);
    end
    @(posedge clk);
    for (int k = 1; k <= lat + LW + 1; k++) begin
      @(negedge clk);
      if (!hold) req[sel] = 1'b0;
      if (k <= lat) begin
        chk("wait_valid", 32'(vld[sel]), 0);
        chk("wait_busy", 32'(busy[sel]), 1);
      end else if (k <= lat + LW) begin
        b = k - lat - 1;
        key = (sel << 20) + int'((base + b) % (longint'(1) << d));
        chk("beat_valid", 32'(vld[sel]), 1);
        chk("beat_idx", 32'(beat[sel]), 32'(b));
        chk("beat_busy", 32'(busy[sel]), 1);
        chk("beat_done", 32'(done[sel]), 0);
        if (!wr) begin
          if (oob || mdl.exists(key)) begin
            exp = oob ? 32'h0 : mdl[key];
            chk($sformatf("fill_s%0d_a%0h_b%0d", sel, addr, b), rd[sel], exp);
            last = exp;
            last_ok = 1'b1;
          end else begin
            last_ok = 1'b0;
          end
        end else begin
          if (b == abort_b) begin
            rst_n = 1'b0;
            #1;
            chk_reset();
            @(negedge clk);
            rst_n = 1'b1;
            req[sel] = 1'b0;
            repeat (3) begin
              @(negedge clk);
              chk("abort_no_done", 32'(done[sel]), 0);
            end
            return;
          end
          mem_wr_data = wd[b];
          if (!oob) mdl[key] = wd[b];
        end
      end else begin
        chk("done_pulse", 32'(done[sel]), 1);
        chk("done_valid", 32'(vld[sel]), 0);
        chk("done_busy", 32'(busy[sel]), 1);
        chk("done_err", 32'(err[sel]), 32'(oob));
        if (!wr && last_ok) chk("done_read_hold", rd[sel], last);
      end
    end
    if (!hold) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy[sel]), 0);
      chk("idle_done", 32'(done[sel]), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_addr = '0;
    mem_wr_en = 1'b0;
    mem_wr_data = '0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < LW; i++) wd[i] = 32'hA0 + 32'(i);
    burst(0, 32'h40, 1'b1, 0, 0, -1);
    burst(0, 32'h42, 1'b0, 0, 0, -1);

    for (int i = 0; i < LW; i++) wd[i] = 32'h11 * 32'(i + 1);
    burst(0, 32'h80, 1'b1, 1, 0, -1);
    burst(0, 32'h80, 1'b0, 0, 1, -1);

    set_wd_rand();
    burst(1, 32'h0, 1'b1, 0, 0, -1);
    burst(1, 32'h0, 1'b0, 0, 0, -1);

    set_wd_rand();
    burst(2, 32'hC, 1'b1, 0, 0, -1);
    burst(2, 32'h1C, 1'b0, 0, 0, -1);
    set_wd_rand();
    burst(2, 32'h1F0, 1'b1, 0, 0, -1);
    burst(2, 32'h0, 1'b0, 0, 0, -1);

    set_wd_rand();
    burst(0, 32'h100, 1'b1, 0, 0, -1);
    for (int i = 0; i < LW; i++) wd[i] = 32'(i + 1);
    burst(0, 32'h100, 1'b1, 0, 0, 2);
    burst(0, 32'h100, 1'b0, 0, 0, -1);

    set_wd_rand();
    burst(0, 32'h0, 1'b1, 0, 0, -1);
    burst(0, 32'h0001_0000, 1'b0, 0, 0, -1);
    set_wd_rand();
    burst(0, 32'h0001_0000, 1'b1, 0, 0, -1);
    burst(0, 32'h0, 1'b0, 0, 0, -1);

    for (int n = 0; n < 24; n++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | 32'h0010_0000;
      set_wd_rand();
      burst(sel, a, 1'($urandom_range(0, 1)), 0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/line_fill_memory.md
Name: line_fill_memory

Overview:
- Word-addressed backing memory that sits on the memory side of the direct-mapped data cache.
- Answers cache line fills (reads) and line writebacks (writes) as fixed-length bursts of LINE_WORDS 32-bit words.
- Each burst starts after a programmable access latency.
- Uses a req/valid/done handshake, so the cache sequences beats against explicit strobes instead of assuming one word per cycle.

Parameters:
- DEPTH_LOG2, 16: memory holds 2**DEPTH_LOG2 32-bit words.
- LATENCY, 2: wait cycles between request acceptance and the first beat. 0 is legal.
- LINE_WORDS, 4: beats per burst. Power of two, 2..16.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req  in  1  burst request; sampled only in IDLE.
- mem_addr  in  32  word address of the request; low log2(LINE_WORDS) bits are ignored (line-aligned).
- mem_wr_en  in  1  sampled with mem_req: 1 = writeback burst, 0 = fill burst.
- mem_wr_data  in  32  write word for the current beat; sampled on each cycle mem_valid=1 of a write burst.
- mem_read  out  32  read word for the current beat; valid while mem_valid=1 on a fill burst.
- mem_valid  out  1  beat strobe.
- mem_beat  out  log2(LINE_WORDS)  index of the current beat.
- mem_busy  out  1  high from the cycle after acceptance through the DONE cycle.
- mem_done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset (async assert, sync release), all outputs 0:
  - state=IDLE
  - mem_read, mem_valid, mem_beat, mem_busy, mem_done = 0
  - latency counter = 0
  - Memory array is not reset.
- States and transitions: IDLE -> WAIT -> BURST -> DONE -> IDLE.
- IDLE:
  - On mem_req=1, latch base = mem_addr with the low log2(LINE_WORDS) bits zeroed, and latch rw = mem_wr_en.
  - Go to WAIT if LATENCY>0, else directly to BURST.
  - mem_busy=1 from the next cycle.
- WAIT:
  - Counts LATENCY cycles, then goes to BURST.
  - mem_req, mem_addr and mem_wr_en are ignored from acceptance until the return to IDLE.
- BURST:
  - Lasts exactly LINE_WORDS cycles; mem_valid=1 on each, mem_beat counts 0..LINE_WORDS-1.
  - Word index = (base + beat) modulo 2**DEPTH_LOG2; upper address bits are dropped.
  - Fill: mem_read is a registered array output, holding array[base+beat] in the same cycle mem_valid=1 for that beat.
  - Writeback: array[base+beat] <= mem_wr_data at the rising edge ending that beat cycle.
  - After the last beat, go to DONE.
- DONE:
  - One cycle: mem_done=1, mem_valid=0, mem_busy=1.
  - Next cycle returns to IDLE with mem_busy=0.
  - A mem_req held high during DONE is accepted at the first IDLE cycle; minimum gap between bursts is 1 idle cycle.
- Total latency, acceptance edge to first beat: LATENCY+1 cycles.
- Fill-to-done: LATENCY+LINE_WORDS+1 cycles.
- mem_read holds its last value outside BURST; it is 0 only after reset.
- Read-after-write to the same line in back-to-back bursts returns the newly written data; no bypass is needed because the write commits before DONE.
- Reset mid-burst: aborts immediately to IDLE with outputs 0. Beats already written stay in the array; the remaining words are unchanged. No done pulse.

Optional Feature:
- Macro: LINE_FILL_MEMORY_BOUNDS_EN.
- When defined:
  - Adds output port mem_err (1 bit).
  - A request whose mem_addr bits above DEPTH_LOG2-1 are nonzero is accepted and runs the full timing.
  - Every beat returns mem_read=0 and drops writes.
  - mem_err=1 together with the mem_done pulse; mem_err=0 otherwise, including reset.
- When undefined: no mem_err port; upper address bits are ignored and the index wraps modulo 2**DEPTH_LOG2.

Test Plan:
- Defaults: preload words 0x40..0x43 = 0xA0,0xA1,0xA2,0xA3; fill at mem_addr=0x42 -> base 0x40; mem_valid on cycles 3..6 after acceptance; mem_read = 0xA0,0xA1,0xA2,0xA3 with mem_beat 0..3; mem_done on cycle 7.
- Writeback at 0x80 with data 0x11,0x22,0x33,0x44, then fill at 0x80 -> returns 0x11,0x22,0x33,0x44; mem_req held through DONE is accepted on the first IDLE cycle.
- LATENCY=0 fill at 0x0 -> first mem_valid one cycle after acceptance; mem_done 5 cycles after acceptance.
- Wrap: DEPTH_LOG2=4, fill at 0x1C -> reads words 0xC..0xF. Write at 0x1F0 -> lands at 0x0..0x3.
- Reset mid-burst: assert rst_n=0 during beat 2 of a write at 0x100 (data 1,2,3,4) -> all outputs 0 immediately; re-read shows 1,2 at 0x100/0x101 and original data at 0x102/0x103; no mem_done.
- With LINE_FILL_MEMORY_BOUNDS_EN and DEPTH_LOG2=16: fill at 0x0001_0000 -> four beats of mem_read=0, mem_err=1 with mem_done; a write there leaves word 0x0 unchanged.
